zii_slave_decode: RTL and testbench



---
 rtl/zii_slave_decode.sv | 164 ++++++++++++++++
 tb/tb_zii_slave_decode.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zii_slave_decode.sv
// Zorro II slave decoder: matches CPU cycles against the RAM, IDE and SD windows
// assigned by AutoConfig and sequences chip select, OVR_n and DTACK_n with per-region wait states.
module zii_slave_decode #(
   parameter int unsigned RAM_WS = 0,
   parameter int unsigned IO_WS  = 2
) (
   input  logic       C7M,
   input  logic       RESET,
   input  logic       AS_CPU_n,
   input  logic       DS_n,
   input  logic       RW_n,
   input  logic [7:0] A_HIGH,
   input  logic [2:0] BASE_RAM,
   input  logic [7:0] BASE_IDE,
   input  logic [7:0] BASE_SD,
   input  logic       RAM_CONFIGURED_n,
   input  logic       IDE_CONFIGURED_n,
   input  logic       SD_CONFIGURED_n,
   input  logic       JP6,
   output logic       RAM_CE_n,
   output logic       IDE_CS_n,
   output logic       SD_CS_n,
   output logic       OVR_n,
   output logic       DTACK_n,
   output logic       BUSY
);

   localparam logic [2:0] RAM_WS_L = RAM_WS[2:0];
   localparam logic [2:0] IO_WS_L  = IO_WS[2:0];

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_HOLD
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [2:0] r_cnt;
   logic [2:0] w_cnt_next;
   // One-hot latched region: bit 0 RAM, bit 1 IDE, bit 2 SD.
   logic [2:0] r_region;
   logic [2:0] w_region_next;
   logic       r_armed;
   logic       r_ds_n;
   logic [2:0] r_sel_n;
   logic       r_ovr_n;
   logic       r_dtack_n;
   logic       r_busy;

   logic [3:0] w_ram_diff;
   logic       w_ram_in_win;
   logic       w_not_e8;
   logic       w_hit_ram;
   logic       w_hit_ide;
   logic       w_hit_sd;
   logic [2:0] w_hit_vec;
   logic       w_active_next;
   logic       w_dtack_next;
   logic       w_unused;

   // Reads and writes are timed identically, so the direction is not needed here.
   assign w_unused = RW_n;

   // A borrow in the 4-bit difference means the address is below the base; no wrap past A23.
   assign w_ram_diff   = {1'b0, A_HIGH[7:5]} - {1'b0, BASE_RAM};
   assign w_ram_in_win = !w_ram_diff[3] &&
                         (JP6 ? (w_ram_diff[2:0] < 3'd4) : (w_ram_diff[2:0] < 3'd2));
   assign w_not_e8     = (A_HIGH != 8'hE8);

   assign w_hit_ram = w_ram_in_win && !RAM_CONFIGURED_n && w_not_e8;
   assign w_hit_ide = (A_HIGH == BASE_IDE) && !IDE_CONFIGURED_n && w_not_e8;
   assign w_hit_sd  = (A_HIGH == BASE_SD) && !SD_CONFIGURED_n && w_not_e8;

   assign w_hit_vec = {w_hit_sd && !w_hit_ide && !w_hit_ram,
                       w_hit_ide && !w_hit_ram,
                       w_hit_ram};

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_region_next = r_region;
      case (r_state)
         S_IDLE: begin
            w_region_next = 3'b000;
            if (r_armed && !AS_CPU_n && (w_hit_vec != 3'b000)) begin
               w_state_next  = S_WAIT;
               w_region_next = w_hit_vec;
               w_cnt_next    = w_hit_ram ? RAM_WS_L : IO_WS_L;
            end
         end
         S_WAIT: begin
            if (AS_CPU_n) begin
               w_state_next = S_IDLE;
            end else if (r_cnt == 3'd0) begin
               // Registered DS keeps the acknowledge one edge behind the strobe.
               if (!r_ds_n) begin
                  w_state_next = S_ACK;
               end
            end else begin
               w_cnt_next = r_cnt - 3'd1;
            end
         end
         S_ACK: begin
            w_state_next = AS_CPU_n ? S_IDLE : S_HOLD;
         end
         S_HOLD: begin
            if (AS_CPU_n) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign w_active_next = (w_state_next != S_IDLE);
   assign w_dtack_next  = (w_state_next == S_ACK) || (w_state_next == S_HOLD);

   always_ff @(posedge C7M) begin
      if (RESET) begin
         r_state   <= S_IDLE;
         r_cnt     <= 3'd0;
         r_region  <= 3'b000;
         r_armed   <= 1'b0;
         r_ds_n    <= 1'b1;
         r_ovr_n   <= 1'b1;
         r_dtack_n <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_region  <= w_region_next;
         r_armed   <= r_armed || AS_CPU_n;
         r_ds_n    <= DS_n;
         r_ovr_n   <= !w_active_next;
         r_dtack_n <= !w_dtack_next;
         r_busy    <= w_active_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sel
         always_ff @(posedge C7M) begin
            if (RESET) begin
               r_sel_n[gi] <= 1'b1;
            end else begin
               r_sel_n[gi] <= !(w_active_next && w_region_next[gi]);
            end
         end
      end
   endgenerate

   assign RAM_CE_n = r_sel_n[0];
   assign IDE_CS_n = r_sel_n[1];
   assign SD_CS_n  = r_sel_n[2];
   assign OVR_n    = r_ovr_n;
   assign DTACK_n  = r_dtack_n;
   assign BUSY     = r_busy;

endmodule

// File: tb/tb_zii_slave_decode.sv
// Directed bench for zii_slave_decode: a decode vector table plus hand-written
// sequences for wait states, delayed DS, abort and mid-cycle reset.
module tb_zii_slave_decode;

   logic       C7M;
   logic       RESET;
   logic       AS_CPU_n;
   logic       DS_n;
   logic       RW_n;
   logic [7:0] A_HIGH;
   logic [2:0] BASE_RAM;
   logic [7:0] BASE_IDE;
   logic [7:0] BASE_SD;
   logic       RAM_CONFIGURED_n;
   logic       IDE_CONFIGURED_n;
   logic       SD_CONFIGURED_n;
   logic       JP6;
   logic       RAM_CE_n;
   logic       IDE_CS_n;
   logic       SD_CS_n;
   logic       OVR_n;
   logic       DTACK_n;
   logic       BUSY;

   // Output vector order: {RAM_CE_n, IDE_CS_n, SD_CS_n, OVR_n, DTACK_n, BUSY}
   localparam logic [5:0] EXP_NONE    = 6'b111110;
   localparam logic [5:0] EXP_RAM     = 6'b011011;
   localparam logic [5:0] EXP_IDE     = 6'b101011;
   localparam logic [5:0] EXP_SD      = 6'b110011;
   localparam logic [5:0] EXP_RAM_ACK = 6'b011001;
   localparam logic [5:0] EXP_IDE_ACK = 6'b101001;

   typedef struct {
      logic [7:0] a_high;
      logic [2:0] base_ram;
      logic [7:0] base_ide;
      logic [7:0] base_sd;
      logic [2:0] cfg_n;     // {ram, ide, sd}
      logic       jp6;
      logic [5:0] exp_outs;
   } vec_t;

   localparam int N_VEC = 18;
   vec_t vecs [N_VEC];

   int n_cmp = 0;
   int n_bad = 0;

   logic [5:0] outs;
   assign outs = {RAM_CE_n, IDE_CS_n, SD_CS_n, OVR_n, DTACK_n, BUSY};

   zii_slave_decode #(
      .RAM_WS(0),
      .IO_WS (2)
   ) dut (
      .C7M             (C7M),
      .RESET           (RESET),
      .AS_CPU_n        (AS_CPU_n),
      .DS_n            (DS_n),
      .RW_n            (RW_n),
      .A_HIGH          (A_HIGH),
      .BASE_RAM        (BASE_RAM),
      .BASE_IDE        (BASE_IDE),
      .BASE_SD         (BASE_SD),
      .RAM_CONFIGURED_n(RAM_CONFIGURED_n),
      .IDE_CONFIGURED_n(IDE_CONFIGURED_n),
      .SD_CONFIGURED_n (SD_CONFIGURED_n),
      .JP6             (JP6),
      .RAM_CE_n        (RAM_CE_n),
      .IDE_CS_n        (IDE_CS_n),
      .SD_CS_n         (SD_CS_n),
      .OVR_n           (OVR_n),
      .DTACK_n         (DTACK_n),
      .BUSY            (BUSY)
   );

   initial C7M = 1'b0;
   always #5 C7M = ~C7M;

   task automatic tick();
      @(posedge C7M);
      #1;
   endtask

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", name, act, exp_v);
      end else begin
         $display("ok   %s: outs %b", name, act);
      end
   endtask

   task automatic setup(input logic [7:0] a, input logic [2:0] bram, input logic [7:0] bide,
                        input logic [7:0] bsd, input logic [2:0] cfg, input logic jp);
      A_HIGH           = a;
      BASE_RAM         = bram;
      BASE_IDE         = bide;
      BASE_SD          = bsd;
      RAM_CONFIGURED_n = cfg[2];
      IDE_CONFIGURED_n = cfg[1];
      SD_CONFIGURED_n  = cfg[0];
      JP6              = jp;
   endtask

   initial begin
      vecs[0]  = '{8'h46, 3'd1, 8'hE9, 8'hEA, 3'b000, 1'b1, EXP_RAM};
      vecs[1]  = '{8'h20, 3'd1, 8'hE9, 8'hEA, 3'b000, 1'b0, EXP_RAM};
      vecs[2]  = '{8'h5F, 3'd1, 8'hE9, 8'hEA, 3'b000, 1'b0, EXP_RAM};
      vecs[3]  = '{8'h60, 3'd1, 8'hE9, 8'hEA, 3'b000, 1'b0, EXP_NONE};
      vecs[4]  = '{8'h1F, 3'd1, 8'hE9, 8'hEA, 3'b000, 1'b0, EXP_NONE};
      vecs[5]  = '{8'h9F, 3'd1, 8'hE9, 8'hEA, 3'b000, 1'b1, EXP_RAM};
      vecs[6]  = '{8'hA0, 3'd1, 8'hE9, 8'hEA, 3'b000, 1'b1, EXP_NONE};
      vecs[7]  = '{8'hFF, 3'd6, 8'hE9, 8'hEA, 3'b000, 1'b1, EXP_RAM};
      vecs[8]  = '{8'h00, 3'd6, 8'hE9, 8'hEA, 3'b000, 1'b1, EXP_NONE};
      vecs[9]  = '{8'hE9, 3'd1, 8'hE9, 8'hEA, 3'b000, 1'b1, EXP_IDE};
      vecs[10] = '{8'hEA, 3'd1, 8'hE9, 8'hEA, 3'b000, 1'b1, EXP_SD};
      vecs[11] = '{8'hEA, 3'd1, 8'hE9, 8'hEA, 3'b001, 1'b1, EXP_NONE};
      vecs[12] = '{8'hEA, 3'd1, 8'hEA, 8'hEA, 3'b000, 1'b1, EXP_IDE};
      vecs[13] = '{8'hEA, 3'd1, 8'hEA, 8'hEA, 3'b010, 1'b1, EXP_SD};
      vecs[14] = '{8'hE8, 3'd1, 8'hE8, 8'hE8, 3'b000, 1'b1, EXP_NONE};
      vecs[15] = '{8'hE8, 3'd6, 8'hE8, 8'hE8, 3'b000, 1'b1, EXP_NONE};
      vecs[16] = '{8'hE9, 3'd6, 8'hE9, 8'hEA, 3'b000, 1'b1, EXP_RAM};
      vecs[17] = '{8'h46, 3'd1, 8'hE9, 8'hEA, 3'b100, 1'b1, EXP_NONE};

      RESET    = 1'b1;
      AS_CPU_n = 1'b1;
      DS_n     = 1'b1;
      RW_n     = 1'b1;
      setup(8'h00, 3'd0, 8'h00, 8'h00, 3'b111, 1'b0);
      tick();
      tick();
      check("reset_state", outs, EXP_NONE);
      RESET = 1'b0;
      tick();
      check("post_reset_idle", outs, EXP_NONE);

      // Decode table: each entry is one bus cycle held in WAIT (DS stays high).
      for (int i = 0; i < N_VEC; i++) begin
         setup(vecs[i].a_high, vecs[i].base_ram, vecs[i].base_ide, vecs[i].base_sd,
               vecs[i].cfg_n, vecs[i].jp6);
         AS_CPU_n = 1'b1;
         DS_n     = 1'b1;
         tick();
         AS_CPU_n = 1'b0;
         tick();
         check($sformatf("vec%0d_a%02h", i, vecs[i].a_high), outs, vecs[i].exp_outs);
         AS_CPU_n = 1'b1;
         tick();
         check($sformatf("vec%0d_release", i), outs, EXP_NONE);
      end

      // RAM read, zero wait states.
      setup(8'h46, 3'd1, 8'hE9, 8'hEA, 3'b000, 1'b1);
      RW_n = 1'b1;
      tick();
      AS_CPU_n = 1'b0;
      DS_n     = 1'b0;
      tick();
      check("ram_rd_select", outs, EXP_RAM);
      tick();
      check("ram_rd_dtack", outs, EXP_RAM_ACK);
      tick();
      check("ram_rd_hold", outs, EXP_RAM_ACK);
      AS_CPU_n = 1'b1;
      DS_n     = 1'b1;
      tick();
      check("ram_rd_release", outs, EXP_NONE);

      // IDE write, two wait states, DS with AS.
      setup(8'hE9, 3'd1, 8'hE9, 8'hEA, 3'b000, 1'b1);
      RW_n     = 1'b0;
      AS_CPU_n = 1'b0;
      DS_n     = 1'b0;
      tick();
      check("ide_wr_select", outs, EXP_IDE);
      tick();
      check("ide_wr_ws1", outs, EXP_IDE);
      tick();
      check("ide_wr_ws2", outs, EXP_IDE);
      tick();
      check("ide_wr_dtack", outs, EXP_IDE_ACK);
      AS_CPU_n = 1'b1;
      DS_n     = 1'b1;
      tick();
      check("ide_wr_release", outs, EXP_NONE);

      // IDE write with DS delayed five cycles.
      AS_CPU_n = 1'b0;
      tick();
      check("ide_ds_select", outs, EXP_IDE);
      for (int j = 0; j < 5; j++) begin
         tick();
         check($sformatf("ide_ds_wait%0d", j), outs, EXP_IDE);
      end
      DS_n = 1'b0;
      tick();
      check("ide_ds_sampled", outs, EXP_IDE);
      tick();
      check("ide_ds_dtack", outs, EXP_IDE_ACK);
      AS_CPU_n = 1'b1;
      DS_n     = 1'b1;
      RW_n     = 1'b1;
      tick();
      check("ide_ds_release", outs, EXP_NONE);

      // Abort during WAIT; region stays latched despite an address change.
      AS_CPU_n = 1'b0;
      tick();
      check("abort_select", outs, EXP_IDE);
      A_HIGH = 8'h00;
      tick();
      check("abort_latched", outs, EXP_IDE);
      AS_CPU_n = 1'b1;
      tick();
      check("abort_release", outs, EXP_NONE);
      tick();
      check("abort_no_dtack", outs, EXP_NONE);

      // Reset in HOLD with AS held low: no restart until AS goes high then low.
      setup(8'h46, 3'd1, 8'hE9, 8'hEA, 3'b000, 1'b1);
      tick();
      AS_CPU_n = 1'b0;
      DS_n     = 1'b0;
      tick();
      tick();
      tick();
      check("rst_hold", outs, EXP_RAM_ACK);
      RESET = 1'b1;
      tick();
      check("rst_outputs", outs, EXP_NONE);
      RESET = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tick();
         check($sformatf("rst_unarmed%0d", j), outs, EXP_NONE);
      end
      AS_CPU_n = 1'b1;
      DS_n     = 1'b1;
      tick();
      AS_CPU_n = 1'b0;
      tick();
      check("rst_rearmed_select", outs, EXP_RAM);
      AS_CPU_n = 1'b1;
      tick();
      check("rst_rearmed_release", outs, EXP_NONE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
